// File: rtl/data_stack.sv
// data_stack: T/N register pair over a DEPTH-entry spill memory, one op per clock.
// Define STACK_ERR_TRAP_EN to block overflow/underflow ops and raise sticky ovf/unf.
module data_stack #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op,
  input  logic [15:0] din,
  input  logic [15:0] aluRes,
  output logic [15:0] T,
  output logic [15:0] N,
  output logic [4:0]  depth,
  output logic        empty,
  output logic        full,
  output logic        ovf,
  output logic        unf
);
  localparam int SPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] MAXD = 5'(DEPTH + 2);
  localparam logic [SPW-1:0] SPLAST = SPW'(DEPTH - 1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_DROP  = 3'b010;
  localparam logic [2:0] OP_REPL  = 3'b011;
  localparam logic [2:0] OP_BINOP = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_OVER  = 3'b111;

`ifdef STACK_ERR_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [15:0]    mem [DEPTH];
  logic [SPW-1:0] sp, sp_nx, sp_inc, sp_dec;
  logic [15:0]    t_nx, n_nx, fill;
  logic [4:0]     d_nx, d_inc, d_dec;
  logic           we, rd, ovf_ev, unf_ev;
  logic           ge1, ge2, ge3, blk;

  assign empty  = (depth == 5'd0);
  assign full   = (depth == MAXD);
  assign sp_inc = (sp == SPLAST) ? '0 : sp + 1'b1;
  assign sp_dec = (sp == '0) ? SPLAST : sp - 1'b1;
  assign fill   = mem[sp_dec];
  assign d_inc  = full ? depth : depth + 5'd1;
  assign d_dec  = empty ? depth : depth - 5'd1;
  assign ge1    = (depth != 5'd0);
  assign ge2    = (depth >= 5'd2);
  assign ge3    = (depth >= 5'd3);

  always_comb begin
    t_nx   = T;
    n_nx   = N;
    d_nx   = depth;
    we     = 1'b0;
    rd     = 1'b0;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    unique case (op)
      OP_NOP: ;
      OP_PUSH: begin
        ovf_ev = full;
        t_nx   = din;
        if (ge1) n_nx = T;
        we     = ge2;
        d_nx   = d_inc;
      end
      OP_DROP: begin
        unf_ev = !ge1;
        t_nx   = N;
        rd     = ge3;
        n_nx   = ge3 ? fill : '0;
        d_nx   = d_dec;
      end
      OP_REPL: begin
        unf_ev = !ge1;
        t_nx   = aluRes;
      end
      OP_BINOP: begin
        unf_ev = !ge2;
        t_nx   = aluRes;
        rd     = ge3;
        n_nx   = ge3 ? fill : '0;
        d_nx   = d_dec;
      end
      OP_DUP: begin
        ovf_ev = full;
        n_nx   = T;
        we     = ge2;
        d_nx   = d_inc;
      end
      OP_SWAP: begin
        unf_ev = !ge2;
        t_nx   = N;
        n_nx   = T;
      end
      OP_OVER: begin
        ovf_ev = full;
        unf_ev = !ge2;
        t_nx   = N;
        n_nx   = T;
        we     = ge2;
        d_nx   = d_inc;
      end
    endcase
    // a trapped op leaves every piece of state untouched
    blk = TRAP & (ovf_ev | unf_ev);
    if (blk) begin
      t_nx = T;
      n_nx = N;
      d_nx = depth;
      we   = 1'b0;
      rd   = 1'b0;
    end
    sp_nx = we ? sp_inc : (rd ? sp_dec : sp);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      T     <= '0;
      N     <= '0;
      depth <= '0;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      T     <= t_nx;
      N     <= n_nx;
      depth <= d_nx;
      sp    <= sp_nx;
      ovf   <= TRAP & (ovf | ovf_ev);
      unf   <= TRAP & (unf | unf_ev);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) mem[sp] <= N;
  end

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: random + directed ops against a queue-based stack model.
// Expectations go to a scoreboard queue; a monitor compares after each clock.
module tb_data_stack;
  localparam int DEPTH = 16;
  localparam int MAXD  = DEPTH + 2;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] PUSH  = 3'd1;
  localparam logic [2:0] DROP  = 3'd2;
  localparam logic [2:0] REPL  = 3'd3;
  localparam logic [2:0] BINOP = 3'd4;
  localparam logic [2:0] DUP   = 3'd5;
  localparam logic [2:0] SWAP  = 3'd6;
  localparam logic [2:0] OVER  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] din = '0;
  logic [15:0] alu = '0;
  logic [15:0] t, n;
  logic [4:0]  depth;
  logic        empty, full, ovf, unf;

  always #5 clk = ~clk;

  data_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .din(din), .aluRes(alu),
    .T(t), .N(n), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  typedef struct {
    logic [15:0] t;
    logic [15:0] n;
    int          d;
    bit          o;
    bit          u;
    bit          ctn;
    int          id;
  } exp_t;

  exp_t        q[$];
  logic [15:0] stk[$];
  bit          mo = 1'b0;
  bit          mu = 1'b0;
  int          errs = 0;
  int          checks = 0;
  int          nid = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s op#%0d: got %0h expected %0h", nm, id, act, expv);
    end
  endtask

  function automatic int min_d(input logic [2:0] o);
    if (o == DROP || o == REPL) return 1;
    if (o == BINOP || o == SWAP || o == OVER) return 2;
    return 0;
  endfunction

  function automatic bit is_push(input logic [2:0] o);
    return (o == PUSH || o == DUP || o == OVER);
  endfunction

  task automatic apply(input logic [2:0] o, input logic [15:0] dv,
                       input logic [15:0] av);
    logic [15:0] a, b;
    case (o)
      PUSH: stk.push_back(dv);
      DROP: a = stk.pop_back();
      REPL: begin a = stk.pop_back(); stk.push_back(av); end
      BINOP: begin
        a = stk.pop_back();
        b = stk.pop_back();
        stk.push_back(av);
      end
      DUP: begin a = stk[stk.size()-1]; stk.push_back(a); end
      SWAP: begin
        a = stk.pop_back();
        b = stk.pop_back();
        stk.push_back(a);
        stk.push_back(b);
      end
      OVER: begin a = stk[stk.size()-2]; stk.push_back(a); end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] dv,
                       input logic [15:0] av, input bit rn);
    exp_t e;
    int d;
    bit ov, un;
    logic [15:0] tmp;
    @(negedge clk);
    op = o; din = dv; alu = av; rst_n = rn;
    e.ctn = 1'b1;
    if (!rn) begin
      stk.delete();
      mo = 1'b0;
      mu = 1'b0;
    end else begin
      d  = stk.size();
      ov = is_push(o) && d == MAXD;
      un = d < min_d(o);
`ifdef STACK_ERR_TRAP_EN
      if (ov) mo = 1'b1;
      if (un) mu = 1'b1;
      if (!(ov || un)) apply(o, dv, av);
`else
      if (un) e.ctn = 1'b0;
      else begin
        if (ov) tmp = stk.pop_front();
        apply(o, dv, av);
      end
`endif
    end
    e.d  = stk.size();
    e.t  = (e.d >= 1) ? stk[e.d-1] : 16'h0;
    e.n  = (e.d >= 2) ? stk[e.d-2] : 16'h0;
    e.o  = mo;
    e.u  = mu;
    e.id = nid++;
    q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.ctn) begin
        chk("T", e.id, 32'(t), 32'(e.t));
        chk("N", e.id, 32'(n), 32'(e.n));
      end
      chk("depth", e.id, 32'(depth), 32'(e.d));
      chk("empty", e.id, 32'(empty), 32'(e.d == 0));
      chk("full", e.id, 32'(full), 32'(e.d == MAXD));
      chk("ovf", e.id, 32'(ovf), 32'(e.o));
      chk("unf", e.id, 32'(unf), 32'(e.u));
    end
  end

  task automatic setup3();
    issue(NOP, 16'h0, 16'h0, 1'b0);
    issue(PUSH, 16'h0001, 16'h0, 1'b1);
    issue(PUSH, 16'h0002, 16'h0, 1'b1);
    issue(PUSH, 16'h0003, 16'h0, 1'b1);
  endtask

  initial begin
    logic [2:0] o;
    int d, tries;
    bit ok;
    repeat (2) @(posedge clk);

    setup3();
    @(posedge clk); #2;
    chk("mem0_after_3push", nid, 32'(dut.mem[0]), 32'h0001);
    issue(BINOP, 16'h0, 16'h0005, 1'b1);
    @(posedge clk); #2;
    chk("sp_after_binop", nid, 32'(dut.sp), 32'h0);

    setup3();
    issue(SWAP, 16'h0, 16'h0, 1'b1);
    issue(OVER, 16'h0, 16'h0, 1'b1);

    issue(NOP, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 19; i++)
      issue(PUSH, 16'(16'h00A0 + i), 16'h0, 1'b1);

    issue(NOP, 16'h0, 16'h0, 1'b0);
    issue(DROP, 16'h0, 16'h0, 1'b1);
    issue(PUSH, 16'h1234, 16'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      d = stk.size();
      if ($urandom_range(0, 59) == 0) begin
        issue(NOP, 16'h0, 16'h0, 1'b0);
      end else begin
        o = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) o = PUSH;
`ifdef STACK_ERR_TRAP_EN
        ok = ($urandom_range(0, 5) == 0) && !(o == DUP && d == 0);
`else
        ok = 1'b0;
`endif
        tries = 0;
        while (!ok && tries < 20) begin
          ok = d >= min_d(o) && !(is_push(o) && d == MAXD)
               && !(o == DUP && d == 0);
          if (!ok) o = 3'($urandom_range(0, 7));
          tries++;
        end
        if (!ok) o = NOP;
        issue(o, 16'($urandom), 16'($urandom), 1'b1);
      end
    end

    @(negedge clk);
    op = NOP;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
